// File: rtl/pic_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pic_command_sequencer
//  Description : 8259-style command sequencer. Walks the ICW1..ICW4
//                initialization sequence, holds the configuration registers
//                and the IMR, turns OCW2/OCW3 writes into mode bits and
//                one-cycle command pulses, and muxes IRR/ISR/IMR for reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_command_sequencer #(
  parameter logic [7:0] IMR_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_icw1,
  input  logic       wr_a0,
  input  logic       wr_ocw2,
  input  logic       wr_ocw3,
  input  logic [7:0] wdata,
  input  logic       rd,
  input  logic       rd_a0,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic [7:0] rdata,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       buf_mode,
  output logic       ms,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       nonspec_eoi,
  output logic       spec_eoi,
  output logic       set_prio,
  output logic       rotate,
  output logic [2:0] eoi_level,
  output logic       rot_aeoi,
  output logic       special_mask,
  output logic       read_isr,
  output logic       poll_cmd
);

  typedef enum logic [1:0] {
    S_READY     = 2'd0,
    S_WAIT_ICW2 = 2'd1,
    S_WAIT_ICW3 = 2'd2,
    S_WAIT_ICW4 = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_enter_ready;
  logic       r_ic4;

  // Strobe arbitration: ICW1 > A0 write > OCW2 > OCW3; OCWs only act in READY.
  logic w_ready;
  logic w_take_a0;
  logic w_take_ocw2;
  logic w_take_ocw3;
  assign w_ready     = (r_state == S_READY);
  assign w_take_a0   = wr_a0 & ~wr_icw1;
  assign w_take_ocw2 = wr_ocw2 & ~wr_icw1 & ~wr_a0 & w_ready;
  assign w_take_ocw3 = wr_ocw3 & ~wr_icw1 & ~wr_a0 & ~wr_ocw2 & w_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_READY;
    else       r_state <= w_state_next;
  end

  // Next-state decode; flags the edge that completes an init sequence
  always_comb begin
    w_state_next  = r_state;
    w_enter_ready = 1'b0;
    if (wr_icw1) begin
      w_state_next = S_WAIT_ICW2;
    end else if (w_take_a0) begin
      case (r_state)
        S_WAIT_ICW2: begin
          if (!sngl)     w_state_next = S_WAIT_ICW3;
          else if (r_ic4) w_state_next = S_WAIT_ICW4;
          else begin
            w_state_next  = S_READY;
            w_enter_ready = 1'b1;
          end
        end
        S_WAIT_ICW3: begin
          if (r_ic4) w_state_next = S_WAIT_ICW4;
          else begin
            w_state_next  = S_READY;
            w_enter_ready = 1'b1;
          end
        end
        S_WAIT_ICW4: begin
          w_state_next  = S_READY;
          w_enter_ready = 1'b1;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Configuration, mask and mode registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_done    <= 1'b0;
      r_ic4        <= 1'b0;
      ltim         <= 1'b0;
      sngl         <= 1'b0;
      vector_base  <= 5'd0;
      cascade_cfg  <= 8'h00;
      {sfnm, buf_mode, ms, aeoi, upm} <= 5'd0;
      imr          <= IMR_RESET;
      eoi_level    <= 3'd0;
      rot_aeoi     <= 1'b0;
      special_mask <= 1'b0;
      read_isr     <= 1'b0;
    end else if (wr_icw1) begin
      init_done    <= 1'b0;
      r_ic4        <= wdata[0];
      ltim         <= wdata[3];
      sngl         <= wdata[1];
      imr          <= IMR_RESET;
      eoi_level    <= 3'd0;
      rot_aeoi     <= 1'b0;
      special_mask <= 1'b0;
      read_isr     <= 1'b0;
      if (!wdata[0]) {sfnm, buf_mode, ms, aeoi, upm} <= 5'd0;
    end else if (w_take_a0) begin
      if (w_enter_ready) init_done <= 1'b1;
      case (r_state)
        S_WAIT_ICW2: vector_base <= wdata[7:3];
        S_WAIT_ICW3: cascade_cfg <= wdata;
        S_WAIT_ICW4: {sfnm, buf_mode, ms, aeoi, upm} <= wdata[4:0];
        default:     imr <= wdata;
      endcase
    end else if (w_take_ocw2) begin
      eoi_level <= wdata[2:0];
      if (wdata[7:5] == 3'b100) rot_aeoi <= 1'b1;
      if (wdata[7:5] == 3'b000) rot_aeoi <= 1'b0;
    end else if (w_take_ocw3) begin
      if (wdata[1]) read_isr     <= wdata[0];
      if (wdata[6]) special_mask <= wdata[5];
    end
  end

  // One-cycle command pulses, visible in the cycle after the strobe edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nonspec_eoi <= 1'b0;
      spec_eoi    <= 1'b0;
      set_prio    <= 1'b0;
      rotate      <= 1'b0;
      poll_cmd    <= 1'b0;
    end else begin
      nonspec_eoi <= w_take_ocw2 & (wdata[6:5] == 2'b01);
      spec_eoi    <= w_take_ocw2 & (wdata[6:5] == 2'b11);
      set_prio    <= w_take_ocw2 & (wdata[7:5] == 3'b110);
      rotate      <= w_take_ocw2 & wdata[7] & wdata[5];
      poll_cmd    <= w_take_ocw3 & wdata[2];
    end
  end

  // CPU read-back mux
  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      if (rd_a0)         rdata = imr;
      else if (read_isr) rdata = isr;
      else               rdata = irr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pic_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pic_command_sequencer
//  Description : Directed vector bench for pic_command_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_command_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_icw1 = 1'b0, wr_a0 = 1'b0, wr_ocw2 = 1'b0, wr_ocw3 = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd = 1'b0, rd_a0 = 1'b0;
  logic [7:0] irr = 8'h3C, isr = 8'h5A;
  logic [7:0] rdata;
  logic       init_done, ltim, sngl, upm, aeoi, buf_mode, ms, sfnm;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr;
  logic       nonspec_eoi, spec_eoi, set_prio, rotate, rot_aeoi, special_mask, read_isr, poll_cmd;
  logic [2:0] eoi_level;

  int n_checks = 0;
  int n_errors = 0;

  pic_command_sequencer #(.IMR_RESET(8'h00)) dut (
    .clk(clk), .reset(reset),
    .wr_icw1(wr_icw1), .wr_a0(wr_a0), .wr_ocw2(wr_ocw2), .wr_ocw3(wr_ocw3),
    .wdata(wdata), .rd(rd), .rd_a0(rd_a0), .irr(irr), .isr(isr), .rdata(rdata),
    .init_done(init_done), .ltim(ltim), .sngl(sngl), .vector_base(vector_base),
    .cascade_cfg(cascade_cfg), .upm(upm), .aeoi(aeoi), .buf_mode(buf_mode),
    .ms(ms), .sfnm(sfnm), .imr(imr), .nonspec_eoi(nonspec_eoi), .spec_eoi(spec_eoi),
    .set_prio(set_prio), .rotate(rotate), .eoi_level(eoi_level), .rot_aeoi(rot_aeoi),
    .special_mask(special_mask), .read_isr(read_isr), .poll_cmd(poll_cmd)
  );

  always #5 clk = ~clk;

  // strb = {icw1,a0,ocw2,ocw3}; icw4 = {upm,aeoi,buf_mode,ms,sfnm};
  // pulse = {nonspec,spec,set_prio,rotate,poll}; mode = {rot_aeoi,special_mask,read_isr}
  typedef struct {
    logic [3:0] strb;
    logic [7:0] wd;
    logic       e_init;
    logic [1:0] e_ls;
    logic [4:0] e_vb;
    logic [7:0] e_cas;
    logic [4:0] e_icw4;
    logic [7:0] e_imr;
    logic [4:0] e_pulse;
    logic [2:0] e_lvl;
    logic [2:0] e_mode;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic [3:0] strb, input logic [7:0] wd, input logic ini,
                              input logic [1:0] ls, input logic [4:0] vb, input logic [7:0] cas,
                              input logic [4:0] i4, input logic [7:0] im, input logic [4:0] pl,
                              input logic [2:0] lv, input logic [2:0] md);
    vec_t v;
    v.strb = strb; v.wd = wd; v.e_init = ini; v.e_ls = ls; v.e_vb = vb; v.e_cas = cas;
    v.e_icw4 = i4; v.e_imr = im; v.e_pulse = pl; v.e_lvl = lv; v.e_mode = md;
    return v;
  endfunction

  function automatic logic [39:0] exp_of(input vec_t v);
    return {v.e_init, v.e_ls, v.e_vb, v.e_cas, v.e_icw4, v.e_imr, v.e_pulse, v.e_lvl, v.e_mode};
  endfunction

  function automatic logic [39:0] act_now();
    return {init_done, ltim, sngl, vector_base, cascade_cfg, upm, aeoi, buf_mode, ms, sfnm,
            imr, nonspec_eoi, spec_eoi, set_prio, rotate, poll_cmd, eoi_level,
            rot_aeoi, special_mask, read_isr};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One strobe cycle: drive at negedge, release 1ns after the rising edge
  task automatic strobe(input logic [3:0] strb, input logic [7:0] wd);
    @(negedge clk);
    {wr_icw1, wr_a0, wr_ocw2, wr_ocw3} = strb;
    wdata = wd;
    @(posedge clk);
    #1;
    {wr_icw1, wr_a0, wr_ocw2, wr_ocw3} = 4'b0000;
    wdata = 8'h00;
  endtask

  initial begin
    vecs[0]  = mk(4'b1000, 8'h13, 0, 2'b01, 5'h00, 8'h00, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[1]  = mk(4'b0100, 8'h20, 0, 2'b01, 5'h04, 8'h00, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[2]  = mk(4'b0100, 8'h03, 1, 2'b01, 5'h04, 8'h00, 5'h18, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[3]  = mk(4'b1000, 8'h10, 0, 2'b00, 5'h04, 8'h00, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[4]  = mk(4'b0100, 8'h08, 0, 2'b00, 5'h01, 8'h00, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[5]  = mk(4'b0100, 8'h04, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[6]  = mk(4'b0100, 8'hF0, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd0, 3'b000);
    vecs[7]  = mk(4'b0010, 8'h63, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h08, 3'd3, 3'b000);
    vecs[8]  = mk(4'b0010, 8'hA0, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h12, 3'd0, 3'b000);
    vecs[9]  = mk(4'b0010, 8'h80, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd0, 3'b100);
    vecs[10] = mk(4'b0010, 8'hC5, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h04, 3'd5, 3'b100);
    vecs[11] = mk(4'b0010, 8'h47, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd7, 3'b100);
    vecs[12] = mk(4'b0001, 8'h0B, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd7, 3'b101);
    vecs[13] = mk(4'b0001, 8'h68, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd7, 3'b111);
    vecs[14] = mk(4'b0001, 8'h0C, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h01, 3'd7, 3'b111);
    vecs[15] = mk(4'b0010, 8'h20, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h10, 3'd0, 3'b111);
    vecs[16] = mk(4'b0010, 8'h00, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd0, 3'b011);
    vecs[17] = mk(4'b0001, 8'h48, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd0, 3'b001);
    vecs[18] = mk(4'b0001, 8'h0A, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h00, 3'd0, 3'b000);
    vecs[19] = mk(4'b0011, 8'h23, 1, 2'b00, 5'h01, 8'h04, 5'h00, 8'hF0, 5'h10, 3'd3, 3'b000);
    vecs[20] = mk(4'b1100, 8'h17, 0, 2'b01, 5'h01, 8'h04, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[21] = mk(4'b0010, 8'h63, 0, 2'b01, 5'h01, 8'h04, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[22] = mk(4'b0001, 8'h0C, 0, 2'b01, 5'h01, 8'h04, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[23] = mk(4'b0100, 8'hF8, 0, 2'b01, 5'h1F, 8'h04, 5'h00, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[24] = mk(4'b0100, 8'h1F, 1, 2'b01, 5'h1F, 8'h04, 5'h1F, 8'h00, 5'h00, 3'd0, 3'b000);
    vecs[25] = mk(4'b0100, 8'h55, 1, 2'b01, 5'h1F, 8'h04, 5'h1F, 8'h55, 5'h00, 3'd0, 3'b000);

    // Reset state, checked while reset is still asserted
    #1;
    check("reset_state", act_now(), 40'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 26; i++) begin
      strobe(vecs[i].strb, vecs[i].wd);
      check($sformatf("vec%0d", i), act_now(), exp_of(vecs[i]));
    end

    // Read-back mux (READY, imr=55, read_isr=0)
    rd = 1'b0; rd_a0 = 1'b1; #1;
    check("rdata_idle", {32'h0, rdata}, {32'h0, 8'h00});
    rd = 1'b1; rd_a0 = 1'b1; #1;
    check("rdata_imr", {32'h0, rdata}, {32'h0, 8'h55});
    rd_a0 = 1'b0; #1;
    check("rdata_irr", {32'h0, rdata}, {32'h0, 8'h3C});
    strobe(4'b0001, 8'h0B);
    #1;
    check("rdata_isr", {32'h0, rdata}, {32'h0, 8'h5A});
    rd = 1'b0;

    // Command pulse lasts exactly one cycle
    strobe(4'b0010, 8'h63);
    check("pulse_hi", {35'h0, nonspec_eoi, spec_eoi, set_prio, rotate, poll_cmd}, {35'h0, 5'b01000});
    @(posedge clk); #1;
    check("pulse_lo", {35'h0, nonspec_eoi, spec_eoi, set_prio, rotate, poll_cmd}, {35'h0, 5'b00000});

    // Asynchronous reset between clock edges
    @(negedge clk); #2;
    reset = 1'b1; #1;
    check("async_reset", act_now(), 40'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset aborts a sequence; next A0 write acts as OCW1
    strobe(4'b1000, 8'h13);
    @(negedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    strobe(4'b0100, 8'hAA);
    check("abort_ocw1", {26'h0, init_done, vector_base, imr}, {26'h0, 1'b0, 5'h00, 8'hAA});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the directed run is short; never let it hang
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
